uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter START_TO, default 16, the number of cycles to wait for the transmitter to start before abandoning a byte.
REQ-003 SHALL have ports:
  clk  in  1  single clock, rising edge.
  rst  in  1  reset, asynchronous, active-high.
  req_valid  in  NUM_REQ  per-requester byte available.
  req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
  req_last  in  NUM_REQ  byte ends the requester's packet.
  req_ready  out  NUM_REQ  byte of requester i accepted this cycle.
  tx_data  out  8  byte to the transmitter data input.
  tx_send  out  1  one-cycle start pulse to the transmitter send input.
  tx_sending  in  1  transmitter sending status.
  tx_ovf  in  1  transmitter overflow status.
  ovf_clr  in  1  clears the sticky error flags.
  grant_id  out  3  index of the last accepted requester.
  busy  out  1  byte in flight (state != IDLE).
  ovf_err  out  1  sticky: tx_ovf seen.
  to_err  out  1  sticky: start timeout occurred.

Function
REQ-004 SHALL implement FSM states IDLE, SEND, WAIT_START and WAIT_DONE.
REQ-005 IDLE SHALL accept a byte only when tx_sending=0 and at least one eligible req_valid is high.
REQ-006 Acceptance SHALL assert req_ready of the winner combinationally for that cycle only, capture its data into tx_data, update grant_id and go to SEND.
REQ-007 Eligibility SHALL be as follows:
  - Unlocked: all requesters are eligible.
  - Locked: only lock_id is eligible; other req_valid inputs are ignored.
REQ-008 The winner SHALL be chosen round-robin: the first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-009 Accepting a byte with req_last=0 SHALL set lock=1 and lock_id=winner; accepting a byte with req_last=1 SHALL clear lock and set rr_ptr=(winner+1) mod NUM_REQ.
REQ-010 SEND SHALL drive tx_send=1 for exactly one cycle, then go to WAIT_START with the timeout counter cleared.
REQ-011 WAIT_START SHALL go to WAIT_DONE when tx_sending=1.
REQ-012 In WAIT_START, when the counter reaches START_TO-1 with tx_sending still 0, the block SHALL set to_err and go to IDLE; the byte is dropped and the lock is unchanged.
REQ-013 WAIT_DONE SHALL go to IDLE when tx_sending=0.
REQ-014 Minimum spacing SHALL be one byte per transmitter frame plus 2 cycles (IDLE and SEND).
REQ-015 tx_data SHALL hold its value from acceptance until the next acceptance.
REQ-016 ovf_err SHALL set on any cycle with tx_ovf=1; ovf_clr=1 SHALL clear both ovf_err and to_err; set SHALL win over simultaneous clear.
REQ-017 busy SHALL be 1 in every state other than IDLE.
REQ-018 req_ready SHALL be all-zero outside IDLE, and while tx_sending=1 in IDLE.

Reset
REQ-019 While rst=1 the block SHALL force state=IDLE, tx_data=0, tx_send=0, req_ready=0, grant_id=0, busy=0, ovf_err=0, to_err=0, lock=0, lock_id=0, rr_ptr=0 and counter=0.
REQ-020 Reset asserted mid-byte SHALL abandon the byte; after reset the block SHALL not accept a byte until tx_sending=0, because the transmitter itself has no reset.

Structure
REQ-021 A shared package uart_pkg SHALL hold the FSM state enum, the default START_TO, and the grant index width.
REQ-022 One sub-module, rr_pick, SHALL implement the combinational round-robin selection: inputs eligible mask and rr_ptr; outputs winner index and any-valid.

Verification
REQ-023 Single request: req_valid[0]=1, data=8'hA5, last=1 -> req_ready[0] pulses once, tx_send pulses next cycle with tx_data=A5, and busy stays high until tx_sending falls.
REQ-024 Fairness: all four requesters valid with last=1 -> grant order 0,1,2,3,0 and each req_ready is one cycle wide.
REQ-025 Packet lock: req 2 sends bytes 11,22,33 (last on 33) while req 0 and req 1 are valid -> the transmitter sees 11,22,33 contiguously, then a byte from req 3 if valid, else req 0.
REQ-026 Timeout: the transmitter model never raises tx_sending -> to_err=1 after START_TO cycles in WAIT_START, the block returns to IDLE and the next request proceeds; ovf_clr clears to_err.
REQ-027 Overflow with clear: tx_ovf pulse coincident with ovf_clr -> ovf_err=1; ovf_clr alone on the following cycle -> ovf_err=0.
REQ-028 Reset: rst pulsed in WAIT_DONE while tx_sending=1 -> all outputs are zero; no req_ready until tx_sending=0, then normal acceptance resumes with rr_ptr=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitStart,
    StWaitDone
  } state_e;

  localparam int unsigned START_TO_DEFAULT = 16;
  localparam int unsigned GRANT_W          = 3;

  // Successor of a requester index, wrapping at n.
  function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] idx,
                                                 input int unsigned        n);
    return (idx == GRANT_W'(n - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or after the pointer.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [GRANT_W-1:0] rr_ptr_i,
  output logic [GRANT_W-1:0] winner_o,
  output logic               any_valid_o
);

  logic [2*NUM_REQ-1:0] rotated;
  logic [GRANT_W:0]     sum;

  // Doubling the mask lets a plain shift implement the wrap-around search.
  always_comb begin
    rotated     = {eligible_i, eligible_i} >> rr_ptr_i;
    winner_o    = '0;
    any_valid_o = 1'b0;
    sum         = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!any_valid_o && rotated[off]) begin
        sum = {1'b0, rr_ptr_i} + (GRANT_W + 1)'(off);
        if (sum >= (GRANT_W + 1)'(NUM_REQ)) begin
          sum = sum - (GRANT_W + 1)'(NUM_REQ);
        end
        winner_o    = GRANT_W'(sum);
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte streams from several requesters onto one UART transmitter,
// keeping packets contiguous and flagging start timeouts and overflows.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned START_TO = START_TO_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_send,
  input  logic                 tx_sending,
  input  logic                 tx_ovf,
  input  logic                 ovf_clr,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 busy,
  output logic                 ovf_err,
  output logic                 to_err
);

  localparam int unsigned CntW = (START_TO > 1) ? $clog2(START_TO) : 1;

  state_e              state_q, state_d;
  logic [7:0]          data_q, data_d;
  logic [GRANT_W-1:0]  grant_q, grant_d;
  logic                lock_q, lock_d;
  logic [GRANT_W-1:0]  lock_id_q, lock_id_d;
  logic [GRANT_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                to_q, to_d;

  logic [NUM_REQ-1:0]  eligible;
  logic [GRANT_W-1:0]  winner;
  logic                any_valid;
  logic                accept;
  logic [7:0]          win_data;
  logic                win_last;
  logic                to_set;

  always_comb begin
    eligible = req_valid;
    if (lock_q) begin
      eligible = req_valid & (NUM_REQ'(1) << lock_id_q);
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .eligible_i  (eligible),
    .rr_ptr_i    (rr_ptr_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  // The transmitter has no reset, so a frame may still be running after ours ends.
  assign accept    = !rst && (state_q == StIdle) && !tx_sending && any_valid;
  assign req_ready = accept ? (NUM_REQ'(1) << winner) : '0;

  always_comb begin
    win_data = '0;
    win_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == GRANT_W'(i)) begin
        win_data = req_data[8*i +: 8];
        win_last = req_last[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    grant_d   = grant_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    to_set    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSend;
          data_d  = win_data;
          grant_d = winner;
          if (win_last) begin
            lock_d   = 1'b0;
            rr_ptr_d = rr_next(winner, NUM_REQ);
          end else begin
            lock_d    = 1'b1;
            lock_id_d = winner;
          end
        end
      end
      StSend: begin
        state_d = StWaitStart;
        cnt_d   = '0;
      end
      StWaitStart: begin
        if (tx_sending) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntW'(START_TO - 1)) begin
          // Drop the byte; a packet lock stays so the stream resumes in order.
          to_set  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!tx_sending) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ovf_d = tx_ovf | (ovf_q & ~ovf_clr);
  assign to_d  = to_set | (to_q & ~ovf_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      data_q    <= '0;
      grant_q   <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      grant_q   <= grant_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      to_q      <= to_d;
    end
  end

  assign tx_data  = data_q;
  assign tx_send  = (state_q == StSend);
  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle);
  assign ovf_err  = ovf_q;
  assign to_err   = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a transmitter model and
// an expected-byte scoreboard checked on every tx_send pulse.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int STO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_send;
  logic            tx_sending = 1'b0;
  logic            tx_ovf = 1'b0;
  logic            ovf_clr = 1'b0;
  logic [2:0]      grant_id;
  logic            busy;
  logic            ovf_err;
  logic            to_err;

  uart_tx_arbiter #(
    .NUM_REQ  (NR),
    .START_TO (STO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_send    (tx_send),
    .tx_sending (tx_sending),
    .tx_ovf     (tx_ovf),
    .ovf_clr    (ovf_clr),
    .grant_id   (grant_id),
    .busy       (busy),
    .ovf_err    (ovf_err),
    .to_err     (to_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester streams {last, data}; heads advance only in the environment block.
  logic [8:0]  rq [NR][$];
  int          rq_head [NR];
  logic [10:0] exp_q [$];
  int          exp_head = 0;

  int   tx_frame = 4;
  int   tx_start_dly = 1;
  bit   tx_dead = 1'b0;
  bit   tx_pend = 1'b0;
  int   tx_dly = 0;
  int   tx_left = 0;
  int   cyc = 0;
  int   acc_cyc = -10;
  bit   prev_send = 1'b0;
  bit   prev_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back({l, d});
  endtask

  task automatic exp_push(input logic [2:0] id, input logic [7:0] d);
    exp_q.push_back({id, d});
  endtask

  function automatic bit rq_all_done();
    for (int i = 0; i < NR; i++) begin
      if (rq_head[i] < rq[i].size()) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (k < 400 && !(exp_head == exp_q.size() && !busy && !tx_sending && !tx_pend &&
                        rq_all_done())) begin
      step();
      k++;
    end
    check({tag, "_drain"}, 32'(k < 400), 1);
  endtask

  // Environment: transmitter model, scoreboard, requester drive and handshake checks.
  always @(negedge clk) begin
    logic [8:0] ent;
    cyc++;
    if (tx_pend) begin
      if (tx_dly == 0) begin
        tx_sending = 1'b1;
        tx_pend    = 1'b0;
        tx_left    = tx_frame;
      end else begin
        tx_dly--;
      end
    end else if (tx_sending) begin
      tx_left--;
      if (tx_left <= 0) tx_sending = 1'b0;
    end
    if (tx_send) begin
      check("send_width", 32'(prev_send), 0);
      check("send_latency", cyc, acc_cyc + 1);
      check("exp_pending", 32'(exp_head < exp_q.size()), 1);
      if (exp_head < exp_q.size()) begin
        check("tx_data", tx_data, 32'(exp_q[exp_head][7:0]));
        check("grant_id", grant_id, 32'(exp_q[exp_head][10:8]));
        exp_head++;
      end
      if (!tx_dead) begin
        tx_pend = 1'b1;
        tx_dly  = tx_start_dly;
      end
    end
    prev_send = tx_send;
    for (int i = 0; i < NR; i++) begin
      if (rq_head[i] < rq[i].size()) begin
        ent                = rq[i][rq_head[i]];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = ent[7:0];
        req_last[i]        = ent[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    #1;
    if (req_ready != '0) begin
      check("ready_onehot", 32'($onehot(req_ready)), 1);
      check("ready_valid", 32'(req_ready & ~req_valid), 0);
      check("ready_tx_idle", 32'(tx_sending), 0);
      check("ready_width", 32'(prev_ready), 0);
      acc_cyc = cyc;
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i]) rq_head[i]++;
      end
    end
    prev_ready = (req_ready != '0);
  end

  initial begin
    bit seen;

    // Reset values
    step();
    step();
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_send", 32'(tx_send), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf_err", 32'(ovf_err), 0);
    check("rst_to_err", 32'(to_err), 0);
    rst = 1'b0;
    step();

    // Fairness: grant order 0,1,2,3,0
    push(0, 8'h10, 1'b1); push(1, 8'h21, 1'b1); push(2, 8'h32, 1'b1);
    push(3, 8'h43, 1'b1); push(0, 8'h14, 1'b1);
    exp_push(0, 8'h10); exp_push(1, 8'h21); exp_push(2, 8'h32);
    exp_push(3, 8'h43); exp_push(0, 8'h14);
    drain("fair");

    // Single request, busy until the frame ends, tx_data holds
    push(0, 8'hA5, 1'b1);
    exp_push(0, 8'hA5);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (tx_sending) begin
        seen = 1'b1;
        check("single_busy_sending", 32'(busy), 1);
      end else if (seen) begin
        break;
      end
    end
    check("single_frame_seen", 32'(seen), 1);
    check("single_busy_at_fall", 32'(busy), 1);
    step();
    check("single_busy_after", 32'(busy), 0);
    step();
    step();
    check("single_data_hold", tx_data, 32'h000000A5);

    // Move the pointer to 2 before the lock test
    push(1, 8'h5A, 1'b1);
    exp_push(1, 8'h5A);
    drain("ptr");

    // Packet lock: 11,22,33 contiguous, then 0 and 1
    push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
    push(0, 8'h40, 1'b1); push(1, 8'h41, 1'b1);
    exp_push(2, 8'h11); exp_push(2, 8'h22); exp_push(2, 8'h33);
    exp_push(0, 8'h40); exp_push(1, 8'h41);
    drain("lock");

    // Start timeout
    tx_dead = 1'b1;
    push(1, 8'h5C, 1'b1);
    exp_push(1, 8'h5C);
    for (int k = 0; k < 50; k++) begin
      step();
      if (tx_send) break;
    end
    check("to_send_seen", 32'(tx_send), 1);
    repeat (STO) step();
    check("to_busy_last", 32'(busy), 1);
    check("to_err_early", 32'(to_err), 0);
    step();
    check("to_err_set", 32'(to_err), 1);
    check("to_busy_idle", 32'(busy), 0);
    tx_dead = 1'b0;
    push(3, 8'h3D, 1'b1);
    exp_push(3, 8'h3D);
    drain("to_next");
    check("to_err_sticky", 32'(to_err), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("to_err_clr", 32'(to_err), 0);

    // Overflow with simultaneous clear: set wins
    check("ovf_pre", 32'(ovf_err), 0);
    tx_ovf  = 1'b1;
    ovf_clr = 1'b1;
    step();
    check("ovf_set_wins", 32'(ovf_err), 1);
    tx_ovf = 1'b0;
    step();
    check("ovf_clr", 32'(ovf_err), 0);
    ovf_clr = 1'b0;

    // Reset in WAIT_DONE while the transmitter is still sending
    tx_frame = 30;
    push(1, 8'h99, 1'b1);
    exp_push(1, 8'h99);
    for (int k = 0; k < 50; k++) begin
      step();
      if (busy && tx_sending) break;
    end
    check("rst_reach_wait", 32'(busy && tx_sending), 1);
    step();
    tx_ovf = 1'b1;
    step();
    tx_ovf = 1'b0;
    check("rst_ovf_before", 32'(ovf_err), 1);
    push(0, 8'h88, 1'b1); push(2, 8'h77, 1'b1);
    exp_push(0, 8'h88); exp_push(2, 8'h77);
    rst = 1'b1;
    step();
    check("mid_tx_data", tx_data, 0);
    check("mid_tx_send", 32'(tx_send), 0);
    check("mid_req_ready", 32'(req_ready), 0);
    check("mid_grant_id", 32'(grant_id), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_ovf_err", 32'(ovf_err), 0);
    check("mid_to_err", 32'(to_err), 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (!tx_sending) break;
      check("post_rst_no_ready", 32'(req_ready), 0);
    end
    drain("post_rst");

    check("all_consumed", exp_head, exp_q.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
